// File: rtl/flicker_pkg.sv
// -----------------------------------------------------------------------------
// flicker_pkg
// Shared definitions for the candle-flicker LED driver: FSM state encoding,
// LFSR feedback taps, default brightness width and the LFSR step function.
// -----------------------------------------------------------------------------
package flicker_pkg;

    // Default width of the brightness level and of the PWM counter.
    localparam int PWM_BITS_DEFAULT = 8;

    // Galois feedback taps for the 16-bit right-shifting LFSR.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Flicker controller states.
    typedef enum logic [1:0] {
        OFF  = 2'd0,
        PICK = 2'd1,
        SLEW = 2'd2
    } flicker_state_e;

    // One Galois step: shift right, fold taps back in when a one falls out.
    function automatic logic [15:0] lfsr_step(input logic [15:0] value);
        return value[0] ? ((value >> 1) ^ LFSR_TAPS) : (value >> 1);
    endfunction

endpackage

// File: rtl/flicker_lfsr.sv
// -----------------------------------------------------------------------------
// flicker_lfsr
// 16-bit Galois LFSR used as the random source for flicker targets.
//
// Ports:
//   clk        input   system clock
//   reset      input   synchronous active-high reset, loads SEED
//   advance    input   step the register to lfsr_next this cycle
//   lfsr       output  current register value
//   lfsr_next  output  value the register takes on an advance
// -----------------------------------------------------------------------------
module flicker_lfsr
    import flicker_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        advance,
    output logic [15:0] lfsr,
    output logic [15:0] lfsr_next
);

    // All-zero is a lock-up state for this LFSR; it should never be reached,
    // but if it is the sequence restarts from the seed.
    always_comb begin
        lfsr_next = (lfsr == 16'd0) ? SEED : lfsr_step(lfsr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr <= SEED;
        end else if (advance || (lfsr == 16'd0)) begin
            lfsr <= lfsr_next;
        end
    end

endmodule

// File: rtl/flicker_pwm.sv
// -----------------------------------------------------------------------------
// flicker_pwm
// Candle-flicker LED driver. Random target levels come from an LFSR; the
// brightness slews toward each target by at most STEP per divider tick, and a
// free-running PWM stage turns the brightness into the LED drive.
//
// Ports:
//   clk     input   system clock, all state on rising edge
//   reset   input   synchronous active-high reset
//   tick    input   single-cycle slew strobe from the clock divider
//   enable  input   flicker enable; low forces the LED off
//   led     output  registered PWM LED drive
//   level   output  registered current brightness level
// -----------------------------------------------------------------------------
module flicker_pwm
    import flicker_pkg::*;
#(
    parameter int                  PWM_BITS  = PWM_BITS_DEFAULT,
    parameter logic [15:0]         LFSR_SEED = 16'hACE1,
    parameter logic [PWM_BITS-1:0] MIN_LEVEL = 8'd64,
    parameter logic [PWM_BITS-1:0] STEP      = 8'd4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tick,
    input  logic                enable,
    output logic                led,
    output logic [PWM_BITS-1:0] level
);

    localparam logic [PWM_BITS:0] LEVEL_MAX = {1'b0, {PWM_BITS{1'b1}}};

    flicker_state_e      state;
    logic [PWM_BITS-1:0] target;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] duty;
    logic [15:0]         lfsr_cur;
    logic [15:0]         lfsr_next;
    logic                advance;
    logic [PWM_BITS:0]   slew_dist;
    logic                unused_lfsr_bits;

    // Never let a picked target go below the floor, so the flame stays lit.
    function automatic logic [PWM_BITS-1:0] clamp_target(input logic [PWM_BITS-1:0] raw);
        return (raw < MIN_LEVEL) ? MIN_LEVEL : raw;
    endfunction

    // Magnitude of level - target, computed signed one bit wider so it cannot wrap.
    function automatic logic [PWM_BITS:0] abs_diff(input logic [PWM_BITS-1:0] cur,
                                                   input logic [PWM_BITS-1:0] tgt);
        logic signed [PWM_BITS:0] d;
        d = $signed({1'b0, cur}) - $signed({1'b0, tgt});
        return (d < 0) ? $unsigned(-d) : $unsigned(d);
    endfunction

    // One STEP toward the target, saturated to the representable level range.
    function automatic logic [PWM_BITS-1:0] slew_toward(input logic [PWM_BITS-1:0] cur,
                                                        input logic [PWM_BITS-1:0] tgt);
        logic [PWM_BITS:0] wide;
        if (cur < tgt) begin
            wide = {1'b0, cur} + {1'b0, STEP};
            if (wide > LEVEL_MAX) begin
                wide = LEVEL_MAX;
            end
        end else begin
            wide = (cur < STEP) ? '0 : ({1'b0, cur} - {1'b0, STEP});
        end
        return wide[PWM_BITS-1:0];
    endfunction

    // The LFSR moves only while picking a new target.
    assign advance   = enable && (state == PICK);
    assign slew_dist = abs_diff(level, target);

    // Only the low bits of the next value feed the target; the rest are kept
    // visible for debug.
    assign unused_lfsr_bits = ^{lfsr_cur, lfsr_next[15:PWM_BITS]};

    flicker_lfsr #(
        .SEED(LFSR_SEED)
    ) u_lfsr (
        .clk      (clk),
        .reset    (reset),
        .advance  (advance),
        .lfsr     (lfsr_cur),
        .lfsr_next(lfsr_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= OFF;
            level   <= '0;
            target  <= '0;
            pwm_cnt <= '0;
            duty    <= '0;
            led     <= 1'b0;
        end else begin
            // PWM stage: duty only reloads at the period boundary so a level
            // change never produces a runt pulse mid-period.
            pwm_cnt <= pwm_cnt + 1'b1;
            if (&pwm_cnt) begin
                duty <= level;
            end
            led <= enable && (pwm_cnt < duty);

            // Flicker controller: enable low overrides everything, including tick.
            if (!enable) begin
                state <= OFF;
                level <= '0;
            end else begin
                case (state)
                    OFF: begin
                        level <= '0;
                        state <= PICK;
                    end
                    PICK: begin
                        target <= clamp_target(lfsr_next[PWM_BITS-1:0]);
                        state  <= SLEW;
                    end
                    SLEW: begin
                        if (tick) begin
                            if (slew_dist <= {1'b0, STEP}) begin
                                level <= target;
                                state <= PICK;
                            end else begin
                                level <= slew_toward(level, target);
                            end
                        end
                    end
                    default: begin
                        state <= OFF;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_flicker_pwm.sv
// -----------------------------------------------------------------------------
// tb_flicker_pwm
// Self-checking bench for flicker_pwm. A cycle model predicts level, led,
// state and LFSR for every clock; predictions are queued when inputs are
// driven and popped and compared once the clock edge has produced outputs.
// -----------------------------------------------------------------------------
module tb_flicker_pwm;

    logic       clk;
    logic       reset;
    logic       tick;
    logic       enable;
    logic       led;
    logic [7:0] level;

    int checks;
    int errors;

    typedef struct {
        int level;
        int led;
        int state;
        int lfsr;
    } exp_t;

    exp_t sbq[$];

    // Cycle model state
    int m_state, m_lfsr, m_level, m_target, m_cnt, m_duty, m_led;

    flicker_pwm dut (
        .clk   (clk),
        .reset (reset),
        .tick  (tick),
        .enable(enable),
        .led   (led),
        .level (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit en, input bit tk);
        int n_state, n_lfsr, n_level, n_target, d, raw;
        n_state  = m_state;
        n_lfsr   = m_lfsr;
        n_level  = m_level;
        n_target = m_target;
        if (r) begin
            n_state = 0; n_lfsr = 'hACE1; n_level = 0; n_target = 0;
            m_cnt = 0; m_duty = 0; m_led = 0;
        end else begin
            m_led = (en && (m_cnt < m_duty)) ? 1 : 0;
            if (m_cnt == 255) m_duty = m_level;
            m_cnt = (m_cnt + 1) % 256;
            if (!en) begin
                n_state = 0;
                n_level = 0;
            end else if (m_state == 0) begin
                n_level = 0;
                n_state = 1;
            end else if (m_state == 1) begin
                n_lfsr   = (m_lfsr & 1) ? ((m_lfsr >> 1) ^ 'hB400) : (m_lfsr >> 1);
                raw      = n_lfsr & 255;
                n_target = (raw < 64) ? 64 : raw;
                n_state  = 2;
            end else if (tk) begin
                d = m_level - m_target;
                if (d < 0) d = -d;
                if (d <= 4) begin
                    n_level = m_target;
                    n_state = 1;
                end else begin
                    n_level = (m_level < m_target) ? m_level + 4 : m_level - 4;
                end
            end
        end
        m_state  = n_state;
        m_lfsr   = n_lfsr;
        m_level  = n_level;
        m_target = n_target;
    endtask

    // Drive one clock of stimulus, queue the prediction, compare after the edge.
    task automatic cyc(input bit r, input bit en, input bit tk);
        exp_t e;
        reset  = r;
        enable = en;
        tick   = tk;
        model_step(r, en, tk);
        e.level = m_level;
        e.led   = m_led;
        e.state = m_state;
        e.lfsr  = m_lfsr;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        chk("level", {24'd0, level}, e.level);
        chk("led",   {31'd0, led},   e.led);
        chk("state", {30'd0, dut.state}, e.state);
        chk("lfsr",  {16'd0, dut.lfsr_cur}, e.lfsr);
    endtask

    task automatic tick_then_idle(input int idle);
        cyc(1'b0, 1'b1, 1'b1);
        repeat (idle) cyc(1'b0, 1'b1, 1'b0);
    endtask

    int high_cnt;
    int guard;

    initial begin
        checks = 0;
        errors = 0;
        m_state = 0; m_lfsr = 0; m_level = 0; m_target = 0;
        m_cnt = 0; m_duty = 0; m_led = 0;
        reset = 1'b1; enable = 1'b0; tick = 1'b0;

        // Reset values
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        chk("rst_level", {24'd0, level}, 0);
        chk("rst_led", {31'd0, led}, 0);
        chk("rst_lfsr", {16'd0, dut.lfsr_cur}, 32'hACE1);
        chk("rst_duty", {24'd0, dut.duty}, 0);

        // Enable with no ticks: PICK at +1, SLEW with target at +2
        cyc(1'b0, 1'b1, 1'b0);
        chk("en1_state", {30'd0, dut.state}, 1);
        cyc(1'b0, 1'b1, 1'b0);
        chk("en2_state", {30'd0, dut.state}, 2);
        chk("first_target", {24'd0, dut.target}, 112);
        chk("first_lfsr", {16'd0, dut.lfsr_cur}, 32'hE270);

        // 28 ticks climb 0 -> 112, next pick clamps 56 up to 64
        repeat (28) tick_then_idle(15);
        chk("climb_level", {24'd0, level}, 112);
        chk("second_lfsr", {16'd0, dut.lfsr_cur}, 32'h7138);
        chk("second_target", {24'd0, dut.target}, 64);

        // Level held at 112: exactly 112 high cycles per 256-cycle period
        repeat (256) cyc(1'b0, 1'b1, 1'b0);
        high_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            cyc(1'b0, 1'b1, 1'b0);
            if (led) high_cnt++;
        end
        chk("pwm_high_112", high_cnt, 112);

        // Level change mid-period must not touch duty until the wrap
        guard = 0;
        while (m_cnt != 128 && guard < 300) begin
            cyc(1'b0, 1'b1, 1'b0);
            guard++;
        end
        chk("midperiod_reached", (m_cnt == 128) ? 1 : 0, 1);
        cyc(1'b0, 1'b1, 1'b1);
        chk("mid_level", {24'd0, level}, 108);
        chk("mid_duty_held", {24'd0, dut.duty}, 112);
        repeat (14) cyc(1'b0, 1'b1, 1'b0);

        // Descend to 64 (12 ticks total)
        repeat (10) tick_then_idle(15);
        cyc(1'b0, 1'b1, 1'b1);
        chk("desc_level", {24'd0, level}, 64);
        chk("desc_state", {30'd0, dut.state}, 1);

        // Tick during PICK is ignored; next tick in SLEW steps normally
        cyc(1'b0, 1'b1, 1'b1);
        chk("pick_tick_level", {24'd0, level}, 64);
        chk("third_target", {24'd0, dut.target}, 156);
        cyc(1'b0, 1'b1, 1'b1);
        chk("slew_after_pick", {24'd0, level}, 68);

        // Enable drop with simultaneous tick: enable wins, no reseed on re-enable
        cyc(1'b0, 1'b0, 1'b1);
        chk("drop_state", {30'd0, dut.state}, 0);
        chk("drop_level", {24'd0, level}, 0);
        chk("drop_led", {31'd0, led}, 0);
        chk("drop_lfsr", {16'd0, dut.lfsr_cur}, 32'h389C);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        chk("reen_lfsr", {16'd0, dut.lfsr_cur}, 32'h1C4E);
        chk("reen_target", {24'd0, dut.target}, 78);

        // Reset mid-SLEW restarts the sequence from the seed
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b1);
        chk("pre_rst_level", {24'd0, level}, 8);
        cyc(1'b1, 1'b1, 1'b0);
        chk("mid_rst_level", {24'd0, level}, 0);
        chk("mid_rst_led", {31'd0, led}, 0);
        chk("mid_rst_lfsr", {16'd0, dut.lfsr_cur}, 32'hACE1);
        chk("mid_rst_state", {30'd0, dut.state}, 0);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        chk("rst_repeat_target", {24'd0, dut.target}, 112);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
